// File: rtl/rc_settle_model_mc.sv
// Multi-channel first-order RC settling model: tau reciprocals are computed once per
// calibration by a restoring divider, then one shared multiplier updates channels round-robin.
module rc_settle_model_mc #(
    parameter int NCH        = 4,
    parameter int IN_W       = 9,
    parameter int OUT_W      = 7,
    parameter int ACC_W      = 32,
    parameter int TAU_W      = 16,
    parameter int DIV_N      = 24,
    parameter int COEF_SHIFT = 8,
    parameter int K_REF_RISE = -16,
    parameter int K_REG_RISE = 24,
    parameter int C_RISE     = 64,
    parameter int K_REF_FALL = -8,
    parameter int K_REG_FALL = 12,
    parameter int C_FALL     = 32,
    parameter int TGT_HI     = 105,
    parameter int TGT_LO     = 0,
    parameter int SETTLE_TOL = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IN_W-1:0]        VREF,
    input  logic [IN_W-1:0]        VREG,
    input  logic [NCH-1:0]         dir,
    input  logic                   recal,
    output logic [NCH*OUT_W-1:0]   out,
    output logic [NCH-1:0]         settled,
    output logic                   busy
);

    localparam int FRAC_W = ACC_W - OUT_W;
    localparam int PTR_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W  = $clog2(DIV_N + 1);
    localparam int SUM_W  = IN_W + 34;
    localparam int INV_W  = DIV_N + 1;
    localparam int ERR_W  = ACC_W + 1;
    localparam int PROD_W = ERR_W + INV_W + 1;
    localparam int STEP_W = ACC_W + 2;

    localparam logic signed [SUM_W-1:0] TAU_ONE  = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] TAU_MAX  = SUM_W'((64'd1 << TAU_W) - 64'd1);
    localparam logic [OUT_W-1:0]        TGT_HI_C = OUT_W'(TGT_HI);
    localparam logic [OUT_W-1:0]        TGT_LO_C = OUT_W'(TGT_LO);
    localparam logic signed [OUT_W:0]   TOL_P    = (OUT_W + 1)'(SETTLE_TOL);
    localparam logic signed [OUT_W:0]   TOL_N    = (OUT_W + 1)'(-SETTLE_TOL);

    typedef enum logic [1:0] {ST_CALC, ST_DIV_R, ST_DIV_F, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic               pend_q, pend_d;
    logic               busy_q, busy_d;
    logic [TAU_W-1:0]   tau_rise_q, tau_rise_d, tau_fall_q, tau_fall_d;
    logic [INV_W-1:0]   inv_rise_q, inv_rise_d, inv_fall_q, inv_fall_d;
    logic [TAU_W-1:0]   rem_q, rem_d;
    logic [DIV_N-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q;

    function automatic logic [TAU_W-1:0] clamp_tau(input logic signed [SUM_W-1:0] v);
        if (v < TAU_ONE)
            return TAU_W'(1);
        else if (v > TAU_MAX)
            return '1;
        else
            return v[TAU_W-1:0];
    endfunction

    // tau = C + ((K_ref*VREF + K_reg*VREG) >>> COEF_SHIFT), evaluated at full width
    logic signed [SUM_W-1:0] vref_s, vreg_s, tau_raw_rise, tau_raw_fall;
    assign vref_s = SUM_W'(VREF);
    assign vreg_s = SUM_W'(VREG);
    assign tau_raw_rise = SUM_W'(C_RISE)
        + ((SUM_W'(K_REF_RISE) * vref_s + SUM_W'(K_REG_RISE) * vreg_s) >>> COEF_SHIFT);
    assign tau_raw_fall = SUM_W'(C_FALL)
        + ((SUM_W'(K_REF_FALL) * vref_s + SUM_W'(K_REG_FALL) * vreg_s) >>> COEF_SHIFT);

    // Restoring divide of 2^DIV_N: the dividend has a single 1 at its MSB
    logic [TAU_W-1:0] divisor;
    logic [TAU_W:0]   rem_shift;
    logic             q_bit;
    logic [INV_W-1:0] quo_next;
    assign divisor   = (state_q == ST_DIV_R) ? tau_rise_q : tau_fall_q;
    assign rem_shift = {rem_q, (cnt_q == '0)};
    assign q_bit     = (rem_shift >= {1'b0, divisor});
    assign quo_next  = {quo_q, q_bit};

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        tau_rise_d = tau_rise_q;
        tau_fall_d = tau_fall_q;
        inv_rise_d = inv_rise_q;
        inv_fall_d = inv_fall_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_CALC: begin
                tau_rise_d = clamp_tau(tau_raw_rise);
                tau_fall_d = clamp_tau(tau_raw_fall);
                rem_d      = '0;
                quo_d      = '0;
                cnt_d      = '0;
                pend_d     = pend_q | recal;
                state_d    = ST_DIV_R;
            end
            ST_DIV_R, ST_DIV_F: begin
                pend_d = pend_q | recal;
                rem_d  = q_bit ? TAU_W'(rem_shift - {1'b0, divisor}) : rem_shift[TAU_W-1:0];
                quo_d  = quo_next[DIV_N-1:0];
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIV_N)) begin
                    rem_d = '0;
                    quo_d = '0;
                    cnt_d = '0;
                    if (state_q == ST_DIV_R) begin
                        inv_rise_d = quo_next;
                        state_d    = ST_DIV_F;
                    end else begin
                        inv_fall_d = quo_next;
                        state_d    = (pend_q | recal) ? ST_CALC : ST_RUN;
                        pend_d     = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (recal)
                    state_d = ST_CALC;
            end
            default: state_d = ST_CALC;
        endcase
        busy_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CALC;
            pend_q     <= 1'b0;
            busy_q     <= 1'b1;
            tau_rise_q <= '0;
            tau_fall_q <= '0;
            inv_rise_q <= '0;
            inv_fall_q <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            tau_rise_q <= tau_rise_d;
            tau_fall_q <= tau_fall_d;
            inv_rise_q <= inv_rise_d;
            inv_fall_q <= inv_fall_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy = busy_q;

    // Round-robin pointer parks at 0 outside RUN so channel 0 goes first on entry
    always_ff @(posedge clk) begin
        if (reset || state_q != ST_RUN)
            ptr_q <= '0;
        else if (ptr_q == PTR_W'(NCH - 1))
            ptr_q <= '0;
        else
            ptr_q <= ptr_q + PTR_W'(1);
    end

    // Shared update datapath for the channel selected by ptr_q
    logic [ACC_W-1:0]         o_all [NCH];
    logic [ACC_W-1:0]         o_sel, o_new;
    logic                     dir_sel;
    logic [OUT_W-1:0]         tgt_sel, out_new;
    logic [INV_W-1:0]         inv_sel;
    logic signed [INV_W:0]    inv_s;
    logic signed [ERR_W-1:0]  err;
    logic signed [STEP_W-1:0] step, o_sum;
    logic signed [OUT_W:0]    diff;
    logic                     settled_new;

    assign o_sel   = o_all[ptr_q];
    assign dir_sel = dir[ptr_q];
    assign tgt_sel = dir_sel ? TGT_HI_C : TGT_LO_C;
    assign inv_sel = dir_sel ? inv_rise_q : inv_fall_q;
    assign inv_s   = $signed({1'b0, inv_sel});
    assign err     = $signed({1'b0, tgt_sel, {FRAC_W{1'b0}}}) - $signed({1'b0, o_sel});
    assign step    = STEP_W'((PROD_W'(err) * PROD_W'(inv_s)) >>> DIV_N);
    assign o_sum   = $signed({2'b00, o_sel}) + step;

    always_comb begin
        o_new = o_sum[ACC_W-1:0];
        if (o_sum[STEP_W-1])
            o_new = '0;
        else if (o_sum[ACC_W])
            o_new = '1;
    end

    assign out_new     = o_new[ACC_W-1 -: OUT_W];
    assign diff        = $signed({1'b0, tgt_sel}) - $signed({1'b0, out_new});
    assign settled_new = (diff <= TOL_P) && (diff >= TOL_N);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [ACC_W-1:0] o_q;
            logic [OUT_W-1:0] out_q;
            logic             settled_q;
            logic             upd;

            assign upd = (state_q == ST_RUN) && (ptr_q == PTR_W'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    o_q       <= '0;
                    out_q     <= '0;
                    settled_q <= 1'b0;
                end else if (upd) begin
                    o_q       <= o_new;
                    out_q     <= out_new;
                    settled_q <= settled_new;
                end
            end

            assign o_all[gi]                 = o_q;
            assign out[gi*OUT_W +: OUT_W]    = out_q;
            assign settled[gi]               = settled_q;
        end
    endgenerate

endmodule

// File: tb/tb_rc_settle_model_mc.sv
// Bench for rc_settle_model_mc: three parameter sets share stimulus and are checked every
// cycle against an arithmetic reference model plus scenario-specific constant checks.
module tb_rc_settle_model_mc;

    localparam int NCH   = 4;
    localparam int OUT_W = 7;
    localparam int NI    = 3;
    localparam int CAL   = 51;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic recal = 1'b0;
    logic [8:0] vref = 9'd256;
    logic [8:0] vreg = 9'd256;
    logic [NCH-1:0] dir = '1;

    logic [NCH*OUT_W-1:0] out_w [NI];
    logic [NCH-1:0]       set_w [NI];
    logic                 busy_w [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rc_settle_model_mc u_dut (
        .clk(clk), .reset(reset), .VREF(vref), .VREG(vreg), .dir(dir), .recal(recal),
        .out(out_w[0]), .settled(set_w[0]), .busy(busy_w[0])
    );

    rc_settle_model_mc #(
        .K_REF_RISE(0), .K_REG_RISE(0), .C_RISE(16), .K_REF_FALL(0), .K_REG_FALL(0)
    ) u_c16 (
        .clk(clk), .reset(reset), .VREF(vref), .VREG(vreg), .dir(dir), .recal(recal),
        .out(out_w[1]), .settled(set_w[1]), .busy(busy_w[1])
    );

    rc_settle_model_mc #(
        .K_REF_RISE(0), .K_REG_RISE(0), .C_RISE(-5), .K_REF_FALL(0), .K_REG_FALL(0)
    ) u_clamp (
        .clk(clk), .reset(reset), .VREF(vref), .VREG(vreg), .dir(dir), .recal(recal),
        .out(out_w[2]), .settled(set_w[2]), .busy(busy_w[2])
    );

    // Reference model: per-instance coefficients, channel values as plain integers
    int kref_r [NI] = '{-16, 0, 0};
    int kreg_r [NI] = '{24, 0, 0};
    int c_r    [NI] = '{64, 16, -5};
    int kref_f [NI] = '{-8, 0, 0};
    int kreg_f [NI] = '{12, 0, 0};
    int c_f    [NI] = '{32, 32, 32};

    longint m_o   [NI][NCH];
    int     m_out [NI][NCH];
    bit     m_set [NI][NCH];
    longint inv_r [NI];
    longint inv_f [NI];
    int     calib_left = CAL;
    bit     pend = 1'b0;
    int     ptr = 0;

    function automatic longint calc_inv(int c, int kr, int kg, int a, int b);
        longint t;
        t = longint'(c) + ((longint'(kr) * a + longint'(kg) * b) >>> 8);
        if (t < 1) t = 1;
        if (t > 65535) t = 65535;
        return (longint'(1) << 24) / t;
    endfunction

    function automatic logic [NCH*OUT_W-1:0] exp_out(int i);
        logic [NCH*OUT_W-1:0] v;
        for (int c = 0; c < NCH; c++) v[c*OUT_W +: OUT_W] = OUT_W'(m_out[i][c]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_set(int i);
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_set[i][c];
        return v;
    endfunction

    // Advance the model by one clock using the inputs about to be sampled
    task automatic model_edge();
        longint tgt, inv, err, stp, n;
        if (reset) begin
            for (int i = 0; i < NI; i++)
                for (int c = 0; c < NCH; c++) begin
                    m_o[i][c] = 0; m_out[i][c] = 0; m_set[i][c] = 1'b0;
                end
            calib_left = CAL; pend = 1'b0; ptr = 0;
        end else if (calib_left > 0) begin
            if (calib_left == CAL)
                for (int i = 0; i < NI; i++) begin
                    inv_r[i] = calc_inv(c_r[i], kref_r[i], kreg_r[i], int'(vref), int'(vreg));
                    inv_f[i] = calc_inv(c_f[i], kref_f[i], kreg_f[i], int'(vref), int'(vreg));
                end
            if (recal) pend = 1'b1;
            calib_left--;
            if (calib_left == 0) begin
                ptr = 0;
                if (pend) begin calib_left = CAL; pend = 1'b0; end
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                tgt = dir[ptr] ? 105 : 0;
                inv = dir[ptr] ? inv_r[i] : inv_f[i];
                err = (tgt <<< 25) - m_o[i][ptr];
                stp = (err * inv) >>> 24;
                n = m_o[i][ptr] + stp;
                if (n < 0) n = 0;
                if (n > 64'hFFFF_FFFF) n = 64'hFFFF_FFFF;
                m_o[i][ptr] = n;
                m_out[i][ptr] = int'(n >> 25);
                m_set[i][ptr] = (tgt - m_out[i][ptr] <= 1) && (m_out[i][ptr] - tgt <= 1);
            end
            ptr = (ptr + 1) % NCH;
            if (recal) calib_left = CAL;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dir = NCH'($urandom);
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (out_w[i] !== '0 || set_w[i] !== '0 || busy_w[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_state inst%0d out=%h settled=%b busy=%b required 0/0/1",
                             i, out_w[i], set_w[i], busy_w[i]);
                end
            end
        end
        dir = '1;
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_calibration();
        int bc = 0;
        while (busy_w[0] === 1'b1 && bc < 300) begin
            bc++;
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (out_w[i] !== exp_out(i) || set_w[i] !== exp_set(i) || busy_w[i] !== (calib_left > 0)) begin
                    errors++;
                    $display("FAIL model_cal inst%0d t=%0t out=%h exp=%h settled=%b exp=%b busy=%b exp=%b",
                             i, $time, out_w[i], exp_out(i), set_w[i], exp_set(i), busy_w[i], calib_left > 0);
                end
            end
        end
        checks++;
        if (bc != CAL) begin
            errors++;
            $display("FAIL cal_latency busy cycles=%0d required=%0d", bc, CAL);
        end
        $display("test_calibration: busy for %0d cycles", bc);
    endtask

    task automatic test_first_updates();
        int c;
        for (int k = 0; k < 8; k++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (out_w[i] !== exp_out(i) || set_w[i] !== exp_set(i) || busy_w[i] !== (calib_left > 0)) begin
                    errors++;
                    $display("FAIL model_first inst%0d t=%0t out=%h exp=%h settled=%b exp=%b busy=%b exp=%b",
                             i, $time, out_w[i], exp_out(i), set_w[i], exp_set(i), busy_w[i], calib_left > 0);
                end
            end
            c = k % NCH;
            checks++;
            if (out_w[1][c*OUT_W +: OUT_W] !== ((k < NCH) ? 7'd6 : 7'd12) || set_w[1][c] !== 1'b0) begin
                errors++;
                $display("FAIL tau16_step ch%0d upd%0d out=%0d settled=%b required %0d/0",
                         c, k / NCH, out_w[1][c*OUT_W +: OUT_W], set_w[1][c], (k < NCH) ? 6 : 12);
            end
            checks++;
            if (out_w[2][c*OUT_W +: OUT_W] !== 7'd105 || set_w[2][c] !== 1'b1) begin
                errors++;
                $display("FAIL tau_clamp ch%0d out=%0d settled=%b required 105/1",
                         c, out_w[2][c*OUT_W +: OUT_W], set_w[2][c]);
            end
        end
        $display("test_first_updates done");
    endtask

    task automatic test_random_run();
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 31) == 0) dir[$urandom_range(0, NCH - 1)] ^= 1'b1;
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (out_w[i] !== exp_out(i) || set_w[i] !== exp_set(i) || busy_w[i] !== (calib_left > 0)) begin
                    errors++;
                    $display("FAIL model_rand inst%0d t=%0t out=%h exp=%h settled=%b exp=%b busy=%b exp=%b",
                             i, $time, out_w[i], exp_out(i), set_w[i], exp_set(i), busy_w[i], calib_left > 0);
                end
            end
        end
        $display("test_random_run done");
    endtask

    task automatic test_fall_decay();
        int n = 0;
        int prev;
        int cur;
        dir = '1;
        while (!(out_w[0][OUT_W-1:0] >= 7'd104 && set_w[0][0] === 1'b1) && n < 8000) begin
            n++;
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (out_w[i] !== exp_out(i) || set_w[i] !== exp_set(i) || busy_w[i] !== (calib_left > 0)) begin
                    errors++;
                    $display("FAIL model_rise inst%0d t=%0t out=%h exp=%h settled=%b exp=%b busy=%b exp=%b",
                             i, $time, out_w[i], exp_out(i), set_w[i], exp_set(i), busy_w[i], calib_left > 0);
                end
            end
        end
        checks++;
        if (n >= 8000) begin
            errors++;
            $display("FAIL rise_timeout out0=%0d settled0=%b required >=104/1",
                     out_w[0][OUT_W-1:0], set_w[0][0]);
        end
        dir[0] = 1'b0;
        prev = int'(out_w[0][OUT_W-1:0]);
        cur = prev;
        n = 0;
        while (!(cur == 0 && set_w[0][0] === 1'b1) && n < 8000) begin
            n++;
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (out_w[i] !== exp_out(i) || set_w[i] !== exp_set(i) || busy_w[i] !== (calib_left > 0)) begin
                    errors++;
                    $display("FAIL model_fall inst%0d t=%0t out=%h exp=%h settled=%b exp=%b busy=%b exp=%b",
                             i, $time, out_w[i], exp_out(i), set_w[i], exp_set(i), busy_w[i], calib_left > 0);
                end
            end
            cur = int'(out_w[0][OUT_W-1:0]);
            checks++;
            if (cur > prev) begin
                errors++;
                $display("FAIL fall_monotone out0=%0d required <= %0d", cur, prev);
            end
            prev = cur;
        end
        checks++;
        if (!(cur == 0 && set_w[0][0] === 1'b1)) begin
            errors++;
            $display("FAIL fall_reach out0=%0d settled0=%b required 0/1", cur, set_w[0][0]);
        end
        $display("test_fall_decay: reached 0 after %0d cycles", n);
    endtask

    task automatic test_recal_in_div();
        int bc = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        while (busy_w[0] === 1'b1 && bc < 400) begin
            bc++;
            recal = (bc == 11);
            if (bc == 20) begin
                vref = 9'($urandom_range(0, 511));
                vreg = 9'($urandom_range(0, 511));
            end
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (out_w[i] !== exp_out(i) || set_w[i] !== exp_set(i) || busy_w[i] !== (calib_left > 0)) begin
                    errors++;
                    $display("FAIL model_recdiv inst%0d t=%0t out=%h exp=%h settled=%b exp=%b busy=%b exp=%b",
                             i, $time, out_w[i], exp_out(i), set_w[i], exp_set(i), busy_w[i], calib_left > 0);
                end
            end
        end
        recal = 1'b0;
        checks++;
        if (bc != 2 * CAL) begin
            errors++;
            $display("FAIL recal_div_latency busy cycles=%0d required=%0d", bc, 2 * CAL);
        end
        $display("test_recal_in_div: busy for %0d cycles (vref=%0d vreg=%0d)", bc, vref, vreg);
    endtask

    task automatic test_recal_in_run();
        int bc = 0;
        logic [NCH*OUT_W-1:0] snap [NI];
        for (int k = 0; k < 37; k++) begin
            dir = NCH'($urandom);
            tick();
        end
        recal = 1'b1;
        tick();
        recal = 1'b0;
        for (int i = 0; i < NI; i++) snap[i] = out_w[i];
        while (busy_w[0] === 1'b1 && bc < 300) begin
            bc++;
            tick();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (out_w[i] !== exp_out(i) || set_w[i] !== exp_set(i) || busy_w[i] !== (calib_left > 0)) begin
                    errors++;
                    $display("FAIL model_recrun inst%0d t=%0t out=%h exp=%h settled=%b exp=%b busy=%b exp=%b",
                             i, $time, out_w[i], exp_out(i), set_w[i], exp_set(i), busy_w[i], calib_left > 0);
                end
                checks++;
                if (out_w[i] !== snap[i]) begin
                    errors++;
                    $display("FAIL recal_hold inst%0d out=%h required %h", i, out_w[i], snap[i]);
                end
            end
        end
        checks++;
        if (bc != CAL) begin
            errors++;
            $display("FAIL recal_run_latency busy cycles=%0d required=%0d", bc, CAL);
        end
        $display("test_recal_in_run: busy for %0d cycles", bc);
    endtask

    task automatic test_reset_mid();
        int bc;
        dir = '1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                recal = 1'b1;
                tick();
                recal = 1'b0;
                for (int k = 0; k < 30; k++) tick();
            end else begin
                for (int k = 0; k < 20; k++) tick();
            end
            reset = 1'b1;
            tick();
            reset = 1'b0;
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (out_w[i] !== '0 || set_w[i] !== '0 || busy_w[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_mid%0d inst%0d out=%h settled=%b busy=%b required 0/0/1",
                             pass, i, out_w[i], set_w[i], busy_w[i]);
                end
            end
            bc = 0;
            while (busy_w[0] === 1'b1 && bc < 300) begin
                bc++;
                tick();
                for (int i = 0; i < NI; i++) begin
                    checks++;
                    if (out_w[i] !== exp_out(i) || set_w[i] !== exp_set(i) || busy_w[i] !== (calib_left > 0)) begin
                        errors++;
                        $display("FAIL model_rstmid inst%0d t=%0t out=%h exp=%h settled=%b exp=%b busy=%b exp=%b",
                                 i, $time, out_w[i], exp_out(i), set_w[i], exp_set(i), busy_w[i], calib_left > 0);
                    end
                end
            end
            checks++;
            if (bc != CAL) begin
                errors++;
                $display("FAIL reset_mid%0d_latency busy cycles=%0d required=%0d", pass, bc, CAL);
            end
            $display("test_reset_mid pass %0d: busy for %0d cycles", pass, bc);
        end
    endtask

    initial begin
        test_reset();
        test_calibration();
        test_first_updates();
        test_random_run();
        test_fall_decay();
        test_recal_in_div();
        test_recal_in_run();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
